fir_mavg_scheduler: RTL and testbench

Shares one running-sum moving-average datapath across CH independent sample streams. A round-robin arbiter admits one channel's sample at a time. The block fetches that channel's oldest windowed sample from a per-channel history buffer, updates that channel's running sum, and presents the averaged result with a valid/ready handshake. It sits between the ADC/noise-source channel front ends and the downstream scaling/display stage, and replaces CH copies of the tapped-delay-line filter with one sequenced datapath.

---
 rtl/fir_mavg_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_fir_mavg_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mavg_scheduler.sv
// fir_mavg_scheduler
//   Time-shared running-sum moving-average filter for CH sample streams.
//   A round-robin arbiter admits one channel's sample at a time. The
//   channel's oldest windowed sample is read from its history buffer, its
//   running sum is updated, and the window average is presented on a
//   valid/ready output.
//
//   Sequence per sample: IDLE (accept) -> CALC (update) -> OUT (hold until
//   out_ready). out_valid rises on the second clock edge after acceptance.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   clr         synchronous clear of all channel state, the arbiter and the FSM
//   in_valid    per-channel sample request                   [CH]
//   in_data     packed samples, channel c at [c*N +: N]      [CH*N]
//   in_ready    one-hot grant, asserted only in IDLE         [CH]
//   out_valid   averaged result available
//   out_ready   downstream accepts result
//   out_data    averaged sample                              [N]
//   out_chan    channel index of out_data                    [clog2(CH)]
//   out_primed  window held TAPS samples when out_data was computed
//
// Build option:
//   FIR_MAVG_ROUND_EN  when defined, out_data is rounded half-up and
//                      saturated at 2^N-1. When undefined, out_data is
//                      truncated.

module fir_mavg_scheduler #(
  parameter int N     = 16,
  parameter int CH    = 4,
  parameter int TAPS  = 8,
  parameter int LOG2T = $clog2(TAPS),
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*N-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic [CW-1:0]   out_chan,
  output logic            out_primed
);

  localparam int SW = N + LOG2T;   // running-sum width, holds TAPS*(2^N-1)
  localparam int FW = LOG2T + 1;   // fill counter counts 0..TAPS
  localparam int HW = CW + LOG2T;  // history address {channel, pointer}

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_t;

  state_t         state;
  logic [CW-1:0]  rr_ptr;
  logic [CW-1:0]  cur_ch;
  logic [N-1:0]   cur_data;

  logic [SW-1:0]    sum_q  [CH];
  logic [LOG2T-1:0] ptr_q  [CH];
  logic [FW-1:0]    fill_q [CH];

  // History storage has no reset; a slot is only read once fill says it
  // has been written since the last reset or clear.
  logic [N-1:0]   hist [CH*TAPS];

  logic [CW-1:0]  gnt_idx;
  logic           gnt_found;
  logic [CW-1:0]  next_rr;
  logic [N-1:0]   gnt_data;

  logic [HW-1:0]  hist_addr;
  logic           cur_full;
  logic [N-1:0]   oldest;
  logic [SW-1:0]  new_sum;
  logic [FW-1:0]  new_fill;
  logic [N-1:0]   new_avg;

  // Round-robin search upward from rr_ptr, wrapping. clr masks the grant
  // so a sample is never accepted in the same cycle state is being wiped.
  always_comb begin
    int j;
    logic [CW-1:0] jj;
    j         = 0;
    jj        = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < CH; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= CH) j = j - CH;
      jj = CW'(j);
      if (!gnt_found && in_valid[jj]) begin
        gnt_found = 1'b1;
        gnt_idx   = jj;
      end
    end
    if (state == IDLE && !clr && gnt_found) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    next_rr  = (gnt_idx == CW'(CH - 1)) ? '0 : gnt_idx + 1'b1;
    gnt_data = '0;
    for (int c = 0; c < CH; c++) begin
      if (gnt_idx == CW'(c)) gnt_data = in_data[c*N +: N];
    end
  end

  // Update datapath for the channel captured at acceptance.
  always_comb begin
    hist_addr = {cur_ch, ptr_q[cur_ch]};
    cur_full  = (fill_q[cur_ch] == FW'(TAPS));
    oldest    = cur_full ? hist[hist_addr] : '0;
    // Never negative: oldest was added to this sum TAPS samples ago.
    new_sum   = sum_q[cur_ch] + SW'(cur_data) - SW'(oldest);
    new_fill  = cur_full ? fill_q[cur_ch] : fill_q[cur_ch] + 1'b1;
  end

`ifdef FIR_MAVG_ROUND_EN
  localparam int RW = SW + 1;
  logic [RW-1:0] rnd_sum;
  logic [RW-1:0] rnd_shift;

  // One extra bit so adding TAPS/2 to a full-scale sum cannot wrap.
  always_comb begin
    rnd_sum   = {1'b0, new_sum} + RW'(TAPS / 2);
    rnd_shift = rnd_sum >> LOG2T;
    new_avg   = (rnd_shift > RW'({N{1'b1}})) ? {N{1'b1}} : rnd_shift[N-1:0];
  end
`else
  always_comb begin
    new_avg = new_sum[SW-1:LOG2T];
  end
`endif

  // Main FSM with registered outputs and per-channel state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_ch     <= '0;
      cur_data   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      out_primed <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        sum_q[c]  <= '0;
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
      end
    end else if (clr) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        sum_q[c]  <= '0;
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (|in_ready) begin
            cur_ch   <= gnt_idx;
            cur_data <= gnt_data;
            rr_ptr   <= next_rr;
            state    <= CALC;
          end
        end
        CALC: begin
          sum_q[cur_ch]  <= new_sum;
          ptr_q[cur_ch]  <= ptr_q[cur_ch] + 1'b1;
          fill_q[cur_ch] <= new_fill;
          out_data       <= new_avg;
          out_primed     <= (new_fill == FW'(TAPS));
          out_chan       <= cur_ch;
          out_valid      <= 1'b1;
          state          <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // History write in CALC, into the slot just read as oldest.
  always_ff @(posedge clk) begin
    if (state == CALC && !clr) hist[hist_addr] <= cur_data;
  end

endmodule

// File: tb/tb_fir_mavg_scheduler.sv
// tb_fir_mavg_scheduler
//   Self-checking bench for fir_mavg_scheduler (N=16, CH=4, TAPS=8).
//   Expected results come from a per-channel queue of the last TAPS
//   samples, averaged with plain integer arithmetic. Grant order comes
//   from a simple "next channel after the last winner" rule.

module tb_fir_mavg_scheduler;

  localparam int N    = 16;
  localparam int CH   = 4;
  localparam int TAPS = 8;
  localparam int CW   = 2;

  logic            clk;
  logic            reset_n;
  logic            clr;
  logic [CH-1:0]   in_valid;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_data;
  logic [CW-1:0]   out_chan;
  logic            out_primed;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int mhist [CH][$];

  fir_mavg_scheduler #(.N(N), .CH(CH), .TAPS(TAPS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_primed (out_primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: window average over the last TAPS samples.
  function automatic void model_reset();
    for (int c = 0; c < CH; c++) mhist[c].delete();
  endfunction

  function automatic void model_push(input int c, input int d,
                                     output int ea, output bit ep);
    int s;
    mhist[c].push_back(d);
    if (mhist[c].size() > TAPS) void'(mhist[c].pop_front());
    s = 0;
    foreach (mhist[c][k]) s += mhist[c][k];
`ifdef FIR_MAVG_ROUND_EN
    ea = (s + TAPS / 2) / TAPS;
    if (ea > 65535) ea = 65535;
`else
    ea = s / TAPS;
`endif
    ep = (mhist[c].size() == TAPS);
  endfunction

  // Present a sample on channel c until granted (bounded).
  task automatic accept_sample(input int c, input int d, output bit ok);
    ok = 1'b0;
    in_data[c*N +: N] = N'(d);
    in_valid[c] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready[c]) begin
        @(posedge clk);
        #1;
        in_valid[c] = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    in_valid[c] = 1'b0;
  endtask

  // Wait (bounded) for out_valid at negedges; lat counts negedges since accept.
  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_txn(input int c, input int d, output int od, output int och,
                        output bit op, output int lat, output bit ok);
    bit ok_a;
    bit ok_o;
    od = 0; och = 0; op = 1'b0; lat = 0;
    accept_sample(c, d, ok_a);
    ok_o = 1'b0;
    if (ok_a) wait_out(lat, ok_o);
    ok = ok_a && ok_o;
    if (ok) begin
      od  = int'(out_data);
      och = int'(out_chan);
      op  = out_primed;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== '0) $display("[TB] FAIL reset_out_data got %0d want 0", out_data);
    else pass_cnt++;
    total_cnt++;
    if (out_chan !== '0) $display("[TB] FAIL reset_out_chan got %0d want 0", out_chan);
    else pass_cnt++;
    total_cnt++;
    if (out_primed !== 1'b0) $display("[TB] FAIL reset_out_primed got %0b want 0", out_primed);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== '0) $display("[TB] FAIL reset_in_ready got %b want 0", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_single_channel();
    int od, och, lat, ea;
    bit op, ok, ep;
    do_clr();
    for (int i = 0; i < 11; i++) begin
      do_txn(0, 800, od, och, op, lat, ok);
      model_push(0, 800, ea, ep);
      total_cnt++;
      if (!ok || od !== ea || och !== 0 || op !== ep || lat !== 2)
        $display("[TB] FAIL ch0_seq[%0d] got ok=%0b data=%0d chan=%0d primed=%0b lat=%0d want data=%0d chan=0 primed=%0b lat=2",
                 i, ok, od, och, op, lat, ea, ep);
      else pass_cnt++;
    end
  endtask

  task automatic test_arbitration();
    int data_c [CH];
    int rr, g, ea, lat;
    bit ep, ok, got;
    do_clr();
    rr = 0;
    for (int c = 0; c < CH; c++) begin
      data_c[c] = 8 * (c + 1);
      in_data[c*N +: N] = N'(data_c[c]);
    end
    in_valid = '1;
    for (int k = 0; k < 6; k++) begin
      g = rr;
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (in_ready !== '0) begin
          got = 1'b1;
          break;
        end
      end
      total_cnt++;
      if (!got || in_ready !== CH'(1 << g))
        $display("[TB] FAIL arb_grant[%0d] got %b want %b", k, in_ready, CH'(1 << g));
      else pass_cnt++;
      rr = (g + 1) % CH;
      @(posedge clk);
      #1;
      wait_out(lat, ok);
      model_push(g, data_c[g], ea, ep);
      total_cnt++;
      if (!ok || int'(out_chan) !== g || int'(out_data) !== ea)
        $display("[TB] FAIL arb_result[%0d] got ok=%0b chan=%0d data=%0d want chan=%0d data=%0d",
                 k, ok, out_chan, out_data, g, ea);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    int lat, ea;
    bit ok, ep;
    logic [N-1:0] held;
    int d;
    do_clr();
    d = int'($urandom_range(0, 65535));
    out_ready = 1'b0;
    accept_sample(1, d, ok);
    wait_out(lat, ok);
    model_push(1, d, ea, ep);
    held = out_data;
    total_cnt++;
    if (!ok || int'(out_data) !== ea)
      $display("[TB] FAIL bp_first got ok=%0b data=%0d want %0d", ok, out_data, ea);
    else pass_cnt++;
    in_data[2*N +: N] = 16'h1234;
    in_valid[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== held || out_chan !== 2'd1 || in_ready !== '0)
        $display("[TB] FAIL bp_hold[%0d] got valid=%0b data=%0d chan=%0d ready=%b want 1/%0d/1/0000",
                 i, out_valid, out_data, out_chan, in_ready, held);
      else pass_cnt++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("[TB] FAIL bp_release got out_valid=%0b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_full_scale();
    int od, och, lat, ea;
    bit op, ok, ep;
    do_clr();
    for (int i = 0; i < 9; i++) begin
      do_txn(2, 65535, od, och, op, lat, ok);
      model_push(2, 65535, ea, ep);
      total_cnt++;
      if (!ok || od !== ea || och !== 2 || op !== ep || (i >= 7 && od !== 65535))
        $display("[TB] FAIL full_scale[%0d] got ok=%0b data=%0d chan=%0d primed=%0b want data=%0d primed=%0b",
                 i, ok, od, och, op, ea, ep);
      else pass_cnt++;
    end
  endtask

  task automatic test_clr_in_calc();
    int od, och, lat, ea;
    bit op, ok, ep, seen;
    do_clr();
    for (int i = 0; i < 5; i++) do_txn(1, 40, od, och, op, lat, ok);
    accept_sample(1, 40, ok);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total_cnt++;
    if (!ok || seen)
      $display("[TB] FAIL clr_discard got accepted=%0b out_valid_seen=%0b want 1/0", ok, seen);
    else pass_cnt++;
    @(posedge clk);
    #1;
    do_txn(1, 40, od, och, op, lat, ok);
    model_push(1, 40, ea, ep);
    total_cnt++;
    if (!ok || od !== ea || op !== ep || od !== 5 || op !== 1'b0)
      $display("[TB] FAIL clr_restart got ok=%0b data=%0d primed=%0b want data=%0d primed=%0b",
               ok, od, op, ea, ep);
    else pass_cnt++;
  endtask

  task automatic test_rounding();
    int od, och, lat, ea;
    bit op, ok, ep;
    int want [4];
`ifdef FIR_MAVG_ROUND_EN
    want = '{0, 0, 0, 1};
`else
    want = '{0, 0, 0, 0};
`endif
    do_clr();
    for (int i = 0; i < 4; i++) begin
      do_txn(3, 1, od, och, op, lat, ok);
      model_push(3, 1, ea, ep);
      total_cnt++;
      if (!ok || od !== ea || od !== want[i] || och !== 3)
        $display("[TB] FAIL rounding[%0d] got ok=%0b data=%0d chan=%0d want data=%0d chan=3",
                 i, ok, od, och, want[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    int lat;
    bit ok;
    do_clr();
    out_ready = 1'b0;
    accept_sample(0, 1000, ok);
    wait_out(lat, ok);
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (!ok || out_valid !== 1'b0)
      $display("[TB] FAIL async_reset got ok=%0b out_valid=%0b want 0", ok, out_valid);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int od, och, lat, ea, c, d;
    bit op, ok, ep;
    do_clr();
    for (int i = 0; i < 40; i++) begin
      c = int'($urandom_range(0, CH - 1));
      d = int'($urandom_range(0, 65535));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      do_txn(c, d, od, och, op, lat, ok);
      model_push(c, d, ea, ep);
      total_cnt++;
      if (!ok || od !== ea || och !== c || op !== ep)
        $display("[TB] FAIL random[%0d] ch%0d got ok=%0b data=%0d chan=%0d primed=%0b want data=%0d primed=%0b",
                 i, c, ok, od, och, op, ea, ep);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    clr       = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_single_channel();
    test_arbitration();
    test_backpressure();
    test_full_scale();
    test_clr_in_calc();
    test_rounding();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
